// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions: opcode/condition encodings, F_out field offsets and small decode helpers.
// Also intended for use by the execute stage.
package decode_stage_pkg;

    typedef enum logic [3:0] {
        OpAdd    = 4'h0,
        OpSub    = 4'h1,
        OpXor    = 4'h2,
        OpRed    = 4'h3,
        OpSll    = 4'h4,
        OpSra    = 4'h5,
        OpRor    = 4'h6,
        OpPaddsb = 4'h7,
        OpLw     = 4'h8,
        OpSw     = 4'h9,
        OpLlb    = 4'hA,
        OpLhb    = 4'hB,
        OpB      = 4'hC,
        OpBr     = 4'hD,
        OpPcs    = 4'hE,
        OpHlt    = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        CondNe     = 3'b000,
        CondEq     = 3'b001,
        CondGt     = 3'b010,
        CondLt     = 3'b011,
        CondGe     = 3'b100,
        CondLe     = 3'b101,
        CondOvf    = 3'b110,
        CondUncond = 3'b111
    } cond_e;

    // F_out bundle and instruction field offsets
    localparam int unsigned PcMsb    = 31;
    localparam int unsigned PcLsb    = 16;
    localparam int unsigned InstrMsb = 15;
    localparam int unsigned InstrLsb = 0;
    localparam int unsigned OpMsb    = 15;
    localparam int unsigned OpLsb    = 12;
    localparam int unsigned RdMsb    = 11;
    localparam int unsigned RdLsb    = 8;
    localparam int unsigned RsMsb    = 7;
    localparam int unsigned RsLsb    = 4;
    localparam int unsigned RtMsb    = 3;
    localparam int unsigned RtLsb    = 0;
    localparam int unsigned CondMsb  = 11;
    localparam int unsigned CondLsb  = 9;
    localparam int unsigned BOffMsb  = 8;
    localparam int unsigned Imm4Msb  = 3;
    localparam int unsigned Imm8Msb  = 7;

    // Flag register layout {Z,V,N}
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagN = 0;

    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] flags);
        logic z, v, n;
        z = flags[FlagZ];
        v = flags[FlagV];
        n = flags[FlagN];
        unique case (cond_e'(ccc))
            CondNe:     return !z;
            CondEq:     return z;
            CondGt:     return !z && !n;
            CondLt:     return n;
            CondGe:     return z || (!z && !n);
            CondLe:     return n || z;
            CondOvf:    return v;
            CondUncond: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs(input opcode_e op);
        return !(op inside {OpLlb, OpLhb, OpB, OpPcs, OpHlt});
    endfunction

    // LLB/LHB read rd through the rt port to merge the untouched byte
    function automatic logic uses_rt(input opcode_e op);
        return op inside {OpAdd, OpSub, OpXor, OpRed, OpPaddsb, OpSw, OpLlb, OpLhb};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 16x16 register file: two combinational read ports, one write port, R0 hardwired to zero,
// same-cycle writeback bypass on reads.
module reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rd_addr_a,
    input  logic [3:0]  rd_addr_b,
    output logic [15:0] rd_data_a,
    output logic [15:0] rd_data_b,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data
);

    logic [15:0] regs_q [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 4'd0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (rd_addr_a == 4'd0) begin
            rd_data_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if (rd_addr_b == 4'd0) begin
            rd_data_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: FD pipeline register, field/immediate decode, register read, load-use and
// branch hazard detection, and branch resolution with same-cycle flush.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] F_out,
    input  logic [2:0]  flags_in,
    input  logic        X_regwrite,
    input  logic        X_memread,
    input  logic        X_flagwrite,
    input  logic [3:0]  X_rd,
    input  logic        M_regwrite,
    input  logic [3:0]  M_rd,
    input  logic        W_regwrite,
    input  logic [3:0]  W_rd,
    input  logic [15:0] W_data,
    output logic        stall,
    output logic        flush,
    output logic [15:0] branch_target,
    output logic        D_valid,
    output logic        D_halt,
    output logic [3:0]  D_opcode,
    output logic [3:0]  D_rd,
    output logic [3:0]  D_rs,
    output logic [3:0]  D_rt,
    output logic [15:0] D_rs_data,
    output logic [15:0] D_rt_data,
    output logic [15:0] D_imm,
    output logic [15:0] D_pc_plus_2
);

    logic [31:0] fd_q;
    logic        fd_valid_q;

    logic [15:0] instr;
    logic [15:0] pc_plus_2;
    opcode_e     opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [2:0]  ccc;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        is_branch;
    logic        load_use;
    logic        branch_stall;
    logic        taken;

    assign instr     = fd_q[InstrMsb:InstrLsb];
    assign pc_plus_2 = fd_q[PcMsb:PcLsb];
    assign opcode    = opcode_e'(instr[OpMsb:OpLsb]);
    assign rd        = instr[RdMsb:RdLsb];
    assign rs        = instr[RsMsb:RsLsb];
    assign ccc       = instr[CondMsb:CondLsb];
    assign rt        = (opcode inside {OpSw, OpLlb, OpLhb}) ? rd : instr[RtMsb:RtLsb];

    always_comb begin
        D_imm = '0;
        unique case (opcode)
            OpLw, OpSw:        D_imm = {{11{instr[Imm4Msb]}}, instr[Imm4Msb:0], 1'b0};
            OpSll, OpSra, OpRor: D_imm = {12'h000, instr[Imm4Msb:0]};
            OpLlb, OpLhb:      D_imm = {8'h00, instr[Imm8Msb:0]};
            default:           D_imm = '0;
        endcase
    end

    reg_file u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (rs_data),
        .rd_data_b (rt_data),
        .wr_en     (W_regwrite),
        .wr_addr   (W_rd),
        .wr_data   (W_data)
    );

    assign is_branch = (opcode == OpB) || (opcode == OpBr);

    assign load_use = fd_valid_q && X_memread && (X_rd != 4'd0) &&
                      ((uses_rs(opcode) && (X_rd == rs)) || (uses_rt(opcode) && (X_rd == rt)));

    // Flags still being produced, or BR's target register still in flight in X or M
    assign branch_stall = fd_valid_q &&
                          ((is_branch && X_flagwrite) ||
                           ((opcode == OpBr) && (rs != 4'd0) &&
                            ((X_regwrite && (X_rd == rs)) || (M_regwrite && (M_rd == rs)))));

    assign stall = load_use || branch_stall;
    assign taken = fd_valid_q && !stall && is_branch && cond_met(ccc, flags_in);
    assign flush = taken;

    always_comb begin
        branch_target = pc_plus_2;
        if (taken) begin
            if (opcode == OpBr) begin
                branch_target = rs_data;
            end else begin
                branch_target = pc_plus_2 + {{6{instr[BOffMsb]}}, instr[BOffMsb:0], 1'b0};
            end
        end
    end

    assign D_valid     = fd_valid_q && !stall;
    assign D_halt      = D_valid && (opcode == OpHlt);
    assign D_opcode    = instr[OpMsb:OpLsb];
    assign D_rd        = rd;
    assign D_rs        = rs;
    assign D_rt        = rt;
    assign D_rs_data   = rs_data;
    assign D_rt_data   = rt_data;
    assign D_pc_plus_2 = pc_plus_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_q       <= '0;
            fd_valid_q <= 1'b0;
        end else if (stall) begin
            fd_q       <= fd_q;
            fd_valid_q <= fd_valid_q;
        end else if (flush) begin
            fd_q       <= '0;
            fd_valid_q <= 1'b0;
        end else begin
            fd_q       <= F_out;
            fd_valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then randomized traffic, predicted by a
// behavioural model of the decode slot and register contents.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] F_out;
    logic [2:0]  flags_in;
    logic        X_regwrite, X_memread, X_flagwrite;
    logic [3:0]  X_rd;
    logic        M_regwrite;
    logic [3:0]  M_rd;
    logic        W_regwrite;
    logic [3:0]  W_rd;
    logic [15:0] W_data;
    logic        stall, flush;
    logic [15:0] branch_target;
    logic        D_valid, D_halt;
    logic [3:0]  D_opcode, D_rd, D_rs, D_rt;
    logic [15:0] D_rs_data, D_rt_data, D_imm, D_pc_plus_2;

    decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .F_out         (F_out),
        .flags_in      (flags_in),
        .X_regwrite    (X_regwrite),
        .X_memread     (X_memread),
        .X_flagwrite   (X_flagwrite),
        .X_rd          (X_rd),
        .M_regwrite    (M_regwrite),
        .M_rd          (M_rd),
        .W_regwrite    (W_regwrite),
        .W_rd          (W_rd),
        .W_data        (W_data),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .D_valid       (D_valid),
        .D_halt        (D_halt),
        .D_opcode      (D_opcode),
        .D_rd          (D_rd),
        .D_rs          (D_rs),
        .D_rt          (D_rt),
        .D_rs_data     (D_rs_data),
        .D_rt_data     (D_rt_data),
        .D_imm         (D_imm),
        .D_pc_plus_2   (D_pc_plus_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, valid, halt;
        logic [3:0]  op, rd, rs, rt;
        logic [15:0] target, rs_data, rt_data, imm, pc2;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    // Model: architectural registers plus the instruction waiting in decode
    logic [15:0] m_regs [16];
    logic [31:0] m_fd;
    bit          m_valid;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] read_model(input logic [3:0] a);
        if (a == 4'd0) return 16'h0;
        if (W_regwrite && (W_rd == a)) return W_data;
        return m_regs[a];
    endfunction

    function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        logic [15:0] ins;
        int          op, off, t;
        bit          use_s, use_t;
        ins       = m_fd[15:0];
        op        = int'(ins[15:12]);
        e.pc2     = m_fd[31:16];
        e.op      = ins[15:12];
        e.rd      = ins[11:8];
        e.rs      = ins[7:4];
        e.rt      = (op inside {9, 10, 11}) ? ins[11:8] : ins[3:0];
        if (op inside {8, 9}) begin
            off = int'(ins[3:0]);
            if (off > 7) off -= 16;
            e.imm = 16'((off * 2) & 'hFFFF);
        end else if (op inside {4, 5, 6}) begin
            e.imm = {12'h0, ins[3:0]};
        end else if (op inside {10, 11}) begin
            e.imm = {8'h0, ins[7:0]};
        end else begin
            e.imm = 16'h0;
        end
        e.rs_data = read_model(e.rs);
        e.rt_data = read_model(e.rt);
        use_s = op inside {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 13};
        use_t = op inside {0, 1, 2, 3, 7, 9, 10, 11};
        e.stall = 1'b0;
        if (m_valid) begin
            if (X_memread && X_rd != 0 &&
                ((use_s && X_rd == e.rs) || (use_t && X_rd == e.rt))) e.stall = 1'b1;
            if ((op inside {12, 13}) && X_flagwrite) e.stall = 1'b1;
            if (op == 13 && e.rs != 0 &&
                ((X_regwrite && X_rd == e.rs) || (M_regwrite && M_rd == e.rs))) e.stall = 1'b1;
        end
        e.flush = m_valid && !e.stall && (op inside {12, 13}) && cond_true(ins[11:9], flags_in);
        e.valid = m_valid && !e.stall;
        e.halt  = e.valid && op == 15;
        e.target = e.pc2;
        if (e.flush && op == 13) begin
            e.target = e.rs_data;
        end else if (e.flush) begin
            off = int'(ins[8:0]);
            if (off > 255) off -= 512;
            t = (int'(e.pc2) + 2 * off) % 65536;
            if (t < 0) t += 65536;
            e.target = 16'(t);
        end
        return e;
    endfunction

    task automatic advance(input exp_t e);
        logic [31:0] nfd;
        bit          nv, we;
        logic [3:0]  wa;
        logic [15:0] wd;
        we = W_regwrite && (W_rd != 0);
        wa = W_rd;
        wd = W_data;
        if (e.stall) begin
            nfd = m_fd;
            nv  = m_valid;
        end else if (e.flush) begin
            nfd = 32'h0;
            nv  = 1'b0;
        end else begin
            nfd = F_out;
            nv  = 1'b1;
        end
        @(posedge clk);
        if (we) m_regs[wa] = wd;
        m_fd    = nfd;
        m_valid = nv;
        #1;
    endtask

    task automatic step();
        exp_t e;
        e = predict();
        sb.push_back(e);
        advance(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_fd    = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic quiet();
        X_regwrite = 0; X_memread = 0; X_flagwrite = 0; X_rd = 0;
        M_regwrite = 0; M_rd = 0;
        W_regwrite = 0; W_rd = 0; W_data = 0;
        flags_in = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 16'(stall), 16'h0);
        chk({tag, "_flush"}, 16'(flush), 16'h0);
        chk({tag, "_valid"}, 16'(D_valid), 16'h0);
        chk({tag, "_halt"}, 16'(D_halt), 16'h0);
        chk({tag, "_bus_ids"}, {D_opcode, D_rd, D_rs, D_rt}, 16'h0);
        chk({tag, "_rs_data"}, D_rs_data, 16'h0);
        chk({tag, "_rt_data"}, D_rt_data, 16'h0);
        chk({tag, "_imm"}, D_imm, 16'h0);
        chk({tag, "_pc2"}, D_pc_plus_2, 16'h0);
        chk({tag, "_target"}, branch_target, 16'h0);
    endtask

    // Monitor: compare every cycle that has a pending prediction
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("stall", 16'(stall), 16'(mon_e.stall));
                chk("flush", 16'(flush), 16'(mon_e.flush));
                chk("d_valid", 16'(D_valid), 16'(mon_e.valid));
                chk("d_halt", 16'(D_halt), 16'(mon_e.halt));
                chk("target", branch_target, mon_e.target);
                chk("ids", {D_opcode, D_rd, D_rs, D_rt},
                    {mon_e.op, mon_e.rd, mon_e.rs, mon_e.rt});
                chk("rs_data", D_rs_data, mon_e.rs_data);
                chk("rt_data", D_rt_data, mon_e.rt_data);
                chk("imm", D_imm, mon_e.imm);
                chk("pc2", D_pc_plus_2, mon_e.pc2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        quiet();
        F_out = 32'h0;
        model_reset();
        #2;
        check_reset_outputs("por");
        #10 rst_n = 1'b1;
        advance(predict());

        // Writeback R2=5, R3=7, then ADD R1,R2,R3
        W_regwrite = 1; W_rd = 2; W_data = 16'd5; step();
        W_rd = 3; W_data = 16'd7; F_out = {16'h0042, 16'h0123}; step();
        quiet(); F_out = {16'h0044, 16'h0541}; #1;
        chk("add_rs_data", D_rs_data, 16'd5);
        chk("add_rt_data", D_rt_data, 16'd7);
        chk("add_rd", 16'(D_rd), 16'd1);
        chk("add_valid", 16'(D_valid), 16'd1);
        step();

        // Load-use on R4: stall one cycle, then release
        X_memread = 1; X_rd = 4; F_out = {16'h0046, 16'h0777}; #1;
        chk("lu_stall", 16'(stall), 16'd1);
        chk("lu_valid", 16'(D_valid), 16'd0);
        step();
        quiet(); F_out = {16'h0010, 16'hC204}; #1;
        chk("lu_release_stall", 16'(stall), 16'd0);
        chk("lu_release_rd", 16'(D_rd), 16'd5);
        chk("lu_release_valid", 16'(D_valid), 16'd1);
        step();

        // B EQ +4 with Z=1; HLT behind it is squashed
        flags_in = 3'b100; F_out = {16'h0012, 16'hF000}; #1;
        chk("b_flush", 16'(flush), 16'd1);
        chk("b_target", branch_target, 16'h0018);
        step();
        flags_in = 0; F_out = {16'h0020, 16'hF000}; #1;
        chk("b_squash_valid", 16'(D_valid), 16'd0);
        chk("b_squash_halt", 16'(D_halt), 16'd0);
        step();

        // HLT reaches decode; meanwhile write R6=0x0200
        W_regwrite = 1; W_rd = 6; W_data = 16'h0200; F_out = {16'h0030, 16'hDE60}; #1;
        chk("hlt_halt", 16'(D_halt), 16'd1);
        chk("hlt_valid", 16'(D_valid), 16'd1);
        step();

        // BR R6 with R6 in flight in M, then resolved
        quiet(); M_regwrite = 1; M_rd = 6; F_out = {16'h0032, 16'h0130}; #1;
        chk("br_stall", 16'(stall), 16'd1);
        chk("br_stall_flush", 16'(flush), 16'd0);
        step();
        quiet(); #1;
        chk("br_flush", 16'(flush), 16'd1);
        chk("br_target", branch_target, 16'h0200);
        step();
        step();

        // Writeback bypass into R3 read, and writes to R0 ignored
        W_regwrite = 1; W_rd = 3; W_data = 16'hBEEF; F_out = {16'h0034, 16'h0100}; #1;
        chk("bypass_rs", D_rs_data, 16'hBEEF);
        step();
        W_rd = 0; W_data = 16'h1234; #1;
        chk("r0_same_cycle", D_rs_data, 16'h0);
        step();
        quiet(); #1;
        chk("r0_after_write", D_rs_data, 16'h0);
        step();

        // Reset pulse while stalled
        F_out = {16'h0100, 16'h0541}; step();
        X_memread = 1; X_rd = 4; F_out = {16'h0102, 16'h0987};
        e = predict();
        sb.push_back(e);
        @(negedge clk);
        chk("pre_rst_stall", 16'(stall), 16'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid_stall");
        quiet(); F_out = {16'h0200, 16'h0321};
        #1 rst_n = 1'b1;
        model_reset();
        advance(predict());
        chk("post_rst_capture_rd", 16'(D_rd), 16'd3);
        chk("post_rst_regs_clear", D_rs_data, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            F_out       = {16'($urandom), 16'($urandom)};
            X_regwrite  = 1'($urandom_range(0, 1));
            X_memread   = ($urandom_range(0, 3) == 0);
            X_flagwrite = ($urandom_range(0, 3) == 0);
            X_rd        = 4'($urandom);
            M_regwrite  = 1'($urandom_range(0, 1));
            M_rd        = 4'($urandom);
            W_regwrite  = 1'($urandom_range(0, 1));
            W_rd        = 4'($urandom);
            W_data      = 16'($urandom);
            flags_in    = 3'($urandom);
            step();
        end

        quiet();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
